// File: rtl/mem_preloader_pkg.sv
// rtl/mem_preloader_pkg.sv - shared state encoding, defaults and helpers for the memory preloader
package mem_preloader_pkg;

   // Session phases of the preloader
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_D = 3'd1,
      ST_LOAD_I = 3'd2,
      ST_RUN    = 3'd3,
      ST_DUMP   = 3'd4,
      ST_DRAIN  = 3'd5,
      ST_DONE   = 3'd6
   } state_e;

   localparam int unsigned IMEM_WORDS_DEF = 512;
   localparam int unsigned DMEM_WORDS_DEF = 1024;
   localparam int unsigned DUMP_WORDS_DEF = 47;
   localparam logic [6:0]  STOP_OPC_DEF   = 7'b1111110;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/mem_preloader.sv
// rtl/mem_preloader.sv - streams DMEM/IMEM images into the cpu, runs it until STOP, dumps DMEM
module mem_preloader
   import mem_preloader_pkg::*;
#(
   parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF,
   parameter int unsigned DMEM_WORDS = DMEM_WORDS_DEF,
   parameter int unsigned DUMP_WORDS = DUMP_WORDS_DEF,
   parameter logic [6:0]  STOP_OPC   = STOP_OPC_DEF
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   output logic [63:0] addr_ext,
   output logic        wen_ext,
   output logic        ren_ext,
   output logic [63:0] wdata_ext,
   output logic [63:0] addr_ext_2,
   output logic        wen_ext_2,
   output logic        ren_ext_2,
   output logic [63:0] wdata_ext_2,
   input  logic [63:0] rdata_ext_2,
   input  logic [31:0] instruction,
   output logic        enable,
   output logic        out_valid,
   output logic [63:0] out_data,
   output logic [3:0]  test_id,
   output logic [31:0] cycles,
   output logic        done
);

   // Counter holds one past the largest count so LOAD_I can park at IMEM_WORDS
   localparam int unsigned CW = $clog2(max3(IMEM_WORDS, DMEM_WORDS, DUMP_WORDS) + 1);
   localparam logic [CW-1:0] D_LAST    = CW'(DMEM_WORDS - 1);
   localparam logic [CW-1:0] I_END     = CW'(IMEM_WORDS);
   localparam logic [CW-1:0] DUMP_LAST = (DUMP_WORDS == 0) ? '0 : CW'(DUMP_WORDS - 1);

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q;
   logic [31:0]    cycles_q;
   logic [3:0]     test_id_q;
   logic           iwen_q, dwen_q, rd_pend_q;
   logic [63:0]    iaddr_q, idata_q, daddr_q, ddata_q;
   logic           accept, stop_hit, acc_d, acc_i;
   logic [63:0]    cnt_addr;
   logic           unused_instr;

   assign unused_instr = ^instruction[27:7];
   assign accept   = in_valid && in_ready;
   assign acc_d    = accept && (state_q == ST_LOAD_D);
   assign acc_i    = accept && (state_q == ST_LOAD_I);
   assign stop_hit = (state_q == ST_RUN) && (instruction[6:0] == STOP_OPC);
   assign cnt_addr = {{(61 - CW){1'b0}}, cnt_q, 3'b000};

   // State register
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; LOAD_I lingers one cycle after its last accept so the final
   // IMEM write lands before the cpu is enabled
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (start) state_d = ST_LOAD_D;
         ST_LOAD_D:        if (accept && (cnt_q == D_LAST)) state_d = ST_LOAD_I;
         ST_LOAD_I:        if (cnt_q == I_END) state_d = ST_RUN;
         ST_RUN:           if (stop_hit) state_d = (DUMP_WORDS == 0) ? ST_DONE : ST_DUMP;
         ST_DUMP:          if (cnt_q == DUMP_LAST) state_d = ST_DRAIN;
         ST_DRAIN:         state_d = ST_DONE;
         default:          state_d = ST_IDLE;
      endcase
   end

   // Word counter, registered write ports, run-cycle counter and read latency tracking
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt_q     <= '0;
         cycles_q  <= '0;
         test_id_q <= '0;
         iwen_q    <= 1'b0;
         iaddr_q   <= '0;
         idata_q   <= '0;
         dwen_q    <= 1'b0;
         daddr_q   <= '0;
         ddata_q   <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         if (state_d != state_q)                   cnt_q <= '0;
         else if (accept || (state_q == ST_DUMP)) cnt_q <= cnt_q + 1'b1;
         dwen_q  <= acc_d;
         daddr_q <= acc_d ? cnt_addr : '0;
         ddata_q <= acc_d ? in_data  : '0;
         iwen_q  <= acc_i;
         iaddr_q <= acc_i ? cnt_addr : '0;
         idata_q <= acc_i ? in_data  : '0;
         if ((state_q != ST_RUN) && (state_d == ST_RUN))
            cycles_q <= '0;
         else if ((state_q == ST_RUN) && !stop_hit && (cycles_q != '1))
            cycles_q <= cycles_q + 1'b1;
         if (stop_hit) test_id_q <= instruction[31:28];
         rd_pend_q <= (state_q == ST_DUMP);
      end
   end

   // Output decode; address/data buses stay zero unless a read or write is active
   always_comb begin
      in_ready    = (state_q == ST_LOAD_D) || ((state_q == ST_LOAD_I) && (cnt_q != I_END));
      enable      = (state_q == ST_RUN);
      done        = (state_q == ST_DONE);
      ren_ext     = 1'b0;
      wen_ext     = iwen_q;
      addr_ext    = iaddr_q;
      wdata_ext   = idata_q;
      ren_ext_2   = (state_q == ST_DUMP);
      wen_ext_2   = dwen_q;
      addr_ext_2  = (state_q == ST_DUMP) ? cnt_addr : daddr_q;
      wdata_ext_2 = ddata_q;
      out_valid   = rd_pend_q;
      out_data    = rd_pend_q ? rdata_ext_2 : '0;
      test_id     = test_id_q;
      cycles      = cycles_q;
   end

endmodule

// File: tb/tb_mem_preloader.sv
// tb/tb_mem_preloader.sv - randomized directed bench for mem_preloader with cpu memory model
module tb_mem_preloader;

   localparam int DW = 1024;
   localparam int IW = 512;
   localparam int NW = 47;
   localparam logic [6:0] STOP = 7'b1111110;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        arst_n, start, in_valid, in_ready;
   logic [63:0] in_data, addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, rdata_ext_2, out_data;
   logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2, enable, out_valid, done;
   logic [31:0] instruction, cycles;
   logic [3:0]  test_id;

   mem_preloader dut (
      .clk(clk), .arst_n(arst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
      .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
      .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
      .instruction(instruction), .enable(enable), .out_valid(out_valid), .out_data(out_data),
      .test_id(test_id), .cycles(cycles), .done(done)
   );

   // cpu DMEM: writes land at the edge, reads return one cycle later, junk otherwise
   logic [63:0] dmem [DW];
   always @(posedge clk) begin
      if (wen_ext_2) dmem[addr_ext_2[12:3]] <= wdata_ext_2;
      if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
      else           rdata_ext_2 <= {$urandom, $urandom};
   end

   int checks = 0;
   int errors = 0;
   logic [63:0] dimg [DW];
   logic [63:0] iimg [IW];
   int d_wr, i_wr, rd_n, ov_n;
   logic prev_ren;

   task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [399:0] all_out();
      return {in_ready, enable, wen_ext, ren_ext, addr_ext, wdata_ext, wen_ext_2, ren_ext_2,
              addr_ext_2, wdata_ext_2, out_valid, out_data, test_id, cycles, done};
   endfunction

   function automatic logic [31:0] nonstop();
      logic [31:0] r;
      r = $urandom;
      if (r[6:0] == STOP) r[0] = ~r[0];
      return r;
   endfunction

   // Per-cycle bus checks against the expected images and read order
   task automatic mon();
      if (wen_ext_2) begin
         if (d_wr < DW) begin
            chk("dmem_wr_addr", addr_ext_2, 64'(d_wr) << 3);
            chk("dmem_wr_data", wdata_ext_2, dimg[d_wr]);
         end else chk("dmem_extra_wr", wen_ext_2, 1'b0);
         d_wr++;
      end
      if (wen_ext) begin
         if (i_wr < IW) begin
            chk("imem_wr_addr", addr_ext, 64'(i_wr) << 3);
            chk("imem_wr_data", wdata_ext, iimg[i_wr]);
         end else chk("imem_extra_wr", wen_ext, 1'b0);
         i_wr++;
      end else chk("imem_idle_bus", {addr_ext, wdata_ext, ren_ext}, 0);
      if (!wen_ext_2 && !ren_ext_2) chk("dmem_idle_bus", {addr_ext_2, wdata_ext_2}, 0);
      if (enable) chk("run_exclusive", {wen_ext, wen_ext_2, ren_ext_2}, 0);
      if (ren_ext_2) begin
         chk("dump_rd_addr", addr_ext_2, 64'(rd_n) << 3);
         rd_n++;
      end
      chk("out_valid_latency", out_valid, prev_ren);
      if (out_valid) begin
         if (ov_n < NW) chk("dump_data", out_data, dimg[ov_n]);
         ov_n++;
      end else chk("out_data_idle", out_data, 0);
      prev_ren = ren_ext_2;
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
   endtask

   task automatic new_session();
      foreach (dimg[i]) dimg[i] = {$urandom, $urandom};
      foreach (iimg[i]) iimg[i] = {$urandom, $urandom};
      d_wr = 0; i_wr = 0; rd_n = 0; ov_n = 0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("done_cleared_by_start", done, 1'b0);
   endtask

   // mode 0: continuous, 1: every other cycle, 2: random
   task automatic load(input int mode, input int stop_at);
      int k, g;
      logic v, tog, acc;
      k = 0; g = 0; tog = 1'b0;
      while (k < stop_at && g < 20000) begin
         tog = ~tog;
         v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
         in_valid = v;
         in_data  = (k < DW) ? dimg[k] : iimg[k - DW];
         acc = v && in_ready;
         tick();
         if (acc) k++;
         g++;
      end
      in_valid = 1'b0;
      chk("load_words_accepted", k, stop_at);
   endtask

   task automatic finish_load();
      chk("last_write_before_enable", {enable, wen_ext}, 2'b01);
      tick();
      chk("enable_rise", enable, 1'b1);
      chk("dmem_write_count", d_wr, DW);
      chk("imem_write_count", i_wr, IW);
   endtask

   task automatic run_stop(input int n, input logic [31:0] stop_instr, input bit pulse);
      int g;
      for (int j = 0; j < n; j++) begin
         chk("cycles_count", cycles, j);
         chk("enable_run", enable, 1'b1);
         instruction = nonstop();
         if (pulse && j == n / 2) start = 1'b1;
         tick();
         start = 1'b0;
      end
      chk("cycles_at_stop", cycles, n);
      instruction = stop_instr;
      tick();
      instruction = nonstop();
      chk("enable_fall", enable, 1'b0);
      chk("test_id", test_id, stop_instr[31:28]);
      chk("cycles_frozen", cycles, n);
      chk("dump_first_read", ren_ext_2, 1'b1);
      g = 0;
      while (!done && g < 200) begin
         tick();
         g++;
      end
      chk("done_reached", done, 1'b1);
      chk("dump_read_count", rd_n, NW);
      chk("dump_out_count", ov_n, NW);
      tick();
      tick();
      chk("done_held", {done, enable, out_valid}, 3'b100);
      chk("cycles_held", cycles, n);
   endtask

   initial begin
      logic [31:0] si;
      arst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; instruction = '0;
      prev_ren = 1'b0;
      new_session();
      #1;
      chk("reset_outputs", all_out(), 0);
      #11 arst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_outputs", all_out(), 0);
      end

      // Continuous load, STOP after 100 cycles, stray start in RUN
      new_session();
      start_pulse();
      load(0, DW + IW);
      finish_load();
      run_stop(100, 32'h4000007E, 1'b1);

      // Half-rate load, random STOP point and test id
      new_session();
      start_pulse();
      load(1, DW + IW);
      finish_load();
      si = $urandom;
      si[6:0] = STOP;
      run_stop($urandom_range(1, 40), si, 1'b0);

      // Reset during LOAD_I word 200, then a full random-valid session
      new_session();
      start_pulse();
      load(2, DW + 200);
      #2 arst_n = 1'b0;
      #1 chk("abort_outputs_zero", all_out(), 0);
      prev_ren = 1'b0;
      tick();
      tick();
      chk("abort_held_zero", all_out(), 0);
      arst_n = 1'b1;
      tick();
      new_session();
      start_pulse();
      load(2, DW + IW);
      finish_load();
      si = $urandom;
      si[6:0] = STOP;
      run_stop($urandom_range(1, 40), si, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
